// File: rtl/alu_multicycle.sv
// Multi-cycle execute-stage ALU with a HI/LO register pair and iterative multiply/divide.
// Single-cycle operations finish one cycle after start. Multiply and divide take WIDTH+1 cycles.
`timescale 1ns/1ps
module alu_multicycle #(
  parameter int WIDTH         = 32,
  parameter int CONTROL_WIDTH = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CONTROL_WIDTH-1:0] control,
  input  logic [WIDTH-1:0]         numberA,
  input  logic [WIDTH-1:0]         numberB,
  output logic [WIDTH-1:0]         result,
  output logic                     zero,
  output logic                     busy,
  output logic                     done,
  output logic                     divByZero,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [CONTROL_WIDTH-1:0] ALU_ZERO  = CONTROL_WIDTH'(0);
  localparam logic [CONTROL_WIDTH-1:0] ALU_ADD   = CONTROL_WIDTH'(1);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SUB   = CONTROL_WIDTH'(2);
  localparam logic [CONTROL_WIDTH-1:0] ALU_AND   = CONTROL_WIDTH'(3);
  localparam logic [CONTROL_WIDTH-1:0] ALU_OR    = CONTROL_WIDTH'(4);
  localparam logic [CONTROL_WIDTH-1:0] ALU_XOR   = CONTROL_WIDTH'(5);
  localparam logic [CONTROL_WIDTH-1:0] ALU_NOR   = CONTROL_WIDTH'(6);
  localparam logic [CONTROL_WIDTH-1:0] ALU_LUI   = CONTROL_WIDTH'(7);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SLL   = CONTROL_WIDTH'(8);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SRL   = CONTROL_WIDTH'(9);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SRA   = CONTROL_WIDTH'(10);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SLT   = CONTROL_WIDTH'(11);
  localparam logic [CONTROL_WIDTH-1:0] ALU_SLTU  = CONTROL_WIDTH'(12);
  localparam logic [CONTROL_WIDTH-1:0] ALU_MULT  = CONTROL_WIDTH'(13);
  localparam logic [CONTROL_WIDTH-1:0] ALU_MULTU = CONTROL_WIDTH'(14);
  localparam logic [CONTROL_WIDTH-1:0] ALU_DIV   = CONTROL_WIDTH'(15);
  localparam logic [CONTROL_WIDTH-1:0] ALU_DIVU  = CONTROL_WIDTH'(16);
  localparam logic [CONTROL_WIDTH-1:0] ALU_MFHI  = CONTROL_WIDTH'(17);
  localparam logic [CONTROL_WIDTH-1:0] ALU_MFLO  = CONTROL_WIDTH'(18);
  localparam logic [CONTROL_WIDTH-1:0] ALU_MTHI  = CONTROL_WIDTH'(19);
  localparam logic [CONTROL_WIDTH-1:0] ALU_MTLO  = CONTROL_WIDTH'(20);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MUL    = 2'd1;
  localparam logic [1:0] DIV    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]         state;
  logic [SW-1:0]      counter;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   aux;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_q;
  logic               neg_r;

  logic               signed_op;
  logic [WIDTH-1:0]   mag_a_c;
  logic [WIDTH-1:0]   mag_b_c;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_fix;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quot_next;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state != IDLE);
  assign zero = (result == '0);

  always_comb begin
    signed_op = (control == ALU_MULT) || (control == ALU_DIV);
    mag_a_c   = (signed_op && numberA[WIDTH-1]) ? ('0 - numberA) : numberA;
    mag_b_c   = (signed_op && numberB[WIDTH-1]) ? ('0 - numberB) : numberB;
    shamt     = numberA[SW-1:0];

    alu_out = '0;
    case (control)
      ALU_ADD:  alu_out = numberA + numberB;
      ALU_SUB:  alu_out = numberA - numberB;
      ALU_AND:  alu_out = numberA & numberB;
      ALU_OR:   alu_out = numberA | numberB;
      ALU_XOR:  alu_out = numberA ^ numberB;
      ALU_NOR:  alu_out = ~(numberA | numberB);
      ALU_LUI:  alu_out = {numberB[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_SLL:  alu_out = numberB << shamt;
      ALU_SRL:  alu_out = numberB >> shamt;
      ALU_SRA:  alu_out = $signed(numberB) >>> shamt;
      ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(numberA) < $signed(numberB))};
      ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (numberA < numberB)};
      ALU_MFHI: alu_out = hi;
      ALU_MFLO: alu_out = lo;
      default:  alu_out = '0;
    endcase

    // Multiply: {acc,aux} is the partial product, aux starts as the multiplier and shifts out.
    mul_sum  = {1'b0, acc} + (aux[0] ? {1'b0, mag_b} : '0);
    mul_next = {mul_sum, aux[WIDTH-1:1]};
    mul_fix  = neg_q ? ('0 - mul_next) : mul_next;

    // Divide: acc is the partial remainder, aux shifts the dividend out and the quotient in.
    div_shift = {acc, aux[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    div_diff  = div_shift - {1'b0, mag_b};
    rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quot_next = {aux[WIDTH-2:0], div_ge};
    quot_fix  = neg_q ? ('0 - quot_next) : quot_next;
    rem_fix   = neg_r ? ('0 - rem_next) : rem_next;
  end

  // Results are written on the edge that enters FINISH, so done and the data appear together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= '0;
      acc       <= '0;
      aux       <= '0;
      mag_b     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result    <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            counter <= '0;
            case (control)
              ALU_MULT, ALU_MULTU: begin
                neg_q <= signed_op && (numberA[WIDTH-1] ^ numberB[WIDTH-1]);
                neg_r <= 1'b0;
                acc   <= '0;
                aux   <= mag_a_c;
                mag_b <= mag_b_c;
                state <= MUL;
              end
              ALU_DIV, ALU_DIVU: begin
                if (numberB == '0) begin
                  lo        <= '1;
                  hi        <= numberA;
                  result    <= '1;
                  done      <= 1'b1;
                  divByZero <= 1'b1;
                  state     <= FINISH;
                end else begin
                  neg_q <= signed_op && (numberA[WIDTH-1] ^ numberB[WIDTH-1]);
                  neg_r <= signed_op && numberA[WIDTH-1];
                  acc   <= '0;
                  aux   <= mag_a_c;
                  mag_b <= mag_b_c;
                  state <= DIV;
                end
              end
              ALU_MTHI: begin
                hi     <= numberA;
                result <= numberA;
                done   <= 1'b1;
                state  <= FINISH;
              end
              ALU_MTLO: begin
                lo     <= numberA;
                result <= numberA;
                done   <= 1'b1;
                state  <= FINISH;
              end
              default: begin
                result <= alu_out;
                done   <= 1'b1;
                state  <= FINISH;
              end
            endcase
          end
        end
        MUL: begin
          counter       <= counter + SW'(1);
          {acc, aux}    <= mul_next;
          if (counter == SW'(WIDTH - 1)) begin
            hi     <= mul_fix[2*WIDTH-1:WIDTH];
            lo     <= mul_fix[WIDTH-1:0];
            result <= mul_fix[WIDTH-1:0];
            done   <= 1'b1;
            state  <= FINISH;
          end
        end
        DIV: begin
          counter <= counter + SW'(1);
          acc     <= rem_next;
          aux     <= quot_next;
          if (counter == SW'(WIDTH - 1)) begin
            lo     <= quot_fix;
            hi     <= rem_fix;
            result <= quot_fix;
            done   <= 1'b1;
            state  <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32 with hand-computed expectations.
`timescale 1ns/1ps
module tb_alu_multicycle;

  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_LUI   = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_SLT   = 5'd11;
  localparam logic [4:0] OP_SLTU  = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_MFHI  = 5'd17;
  localparam logic [4:0] OP_MTHI  = 5'd19;
  localparam logic [4:0] OP_MTLO  = 5'd20;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  control;
  logic [31:0] numberA;
  logic [31:0] numberB;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  alu_multicycle #(.WIDTH(32), .CONTROL_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .start(start), .control(control),
    .numberA(numberA), .numberB(numberB), .result(result), .zero(zero),
    .busy(busy), .done(done), .divByZero(divByZero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one operation once the unit is idle; returns the done latency in cycles.
  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int lat, output bit busy_ok);
    int guard;
    guard = 0;
    @(negedge clock);
    while (busy && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    control = op;
    numberA = a;
    numberB = b;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start   = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit busy_ok;
    int ndone;
    int dlat;
    logic [31:0] r_res, r_hi, r_lo;
    logic        r_dz;

    reset = 1'b0; start = 1'b0; control = '0; numberA = '0; numberB = '0;
    #2;
    chk("rst_result", result, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h1);
    @(negedge clock);
    reset = 1'b1;

    run(OP_MTLO, 32'h55, 32'h0, lat, busy_ok);
    chk("mtlo_lat", lat, 32'd1);
    chk("mtlo_lo", lo, 32'h55);

    // Abort a MULT with reset in cycle 10.
    @(negedge clock);
    while (busy) @(negedge clock);
    control = OP_MULT; numberA = 32'd9; numberB = 32'd9; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    chk("mid_busy", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    chk("abort_result", result, 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_zero", {31'b0, zero}, 32'h1);
    @(negedge clock);
    reset = 1'b1;

    run(OP_ADD, 32'd5, 32'd7, lat, busy_ok);
    chk("add_lat", lat, 32'd1);
    chk("add_result", result, 32'd12);
    chk("add_zero", {31'b0, zero}, 32'h0);

    run(OP_MULT, 32'hFFFFFFFE, 32'd3, lat, busy_ok);
    chk("mult_lat", lat, 32'd33);
    chk("mult_busy", {31'b0, busy_ok}, 32'h1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    chk("mult_result", result, 32'hFFFFFFFA);

    run(OP_MULTU, 32'hFFFFFFFE, 32'd3, lat, busy_ok);
    chk("multu_lat", lat, 32'd33);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);

    run(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, busy_ok);
    chk("div_lat", lat, 32'd33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_dz", {31'b0, divByZero}, 32'h0);

    run(OP_DIVU, 32'd7, 32'd0, lat, busy_ok);
    chk("divz_lat", lat, 32'd1);
    chk("divz_flag", {31'b0, divByZero}, 32'h1);
    chk("divz_lo", lo, 32'hFFFFFFFF);
    chk("divz_hi", hi, 32'd7);

    // INT_MIN / -1 with a stray start pulse in cycle 5.
    @(negedge clock);
    while (busy) @(negedge clock);
    control = OP_DIV; numberA = 32'h80000000; numberB = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    ndone = 0; dlat = 0; r_res = '0; r_hi = '0; r_lo = '0; r_dz = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        ndone++;
        dlat  = c;
        r_res = result; r_hi = hi; r_lo = lo; r_dz = divByZero;
      end
      if (c == 5) begin
        control = OP_ADD; numberA = 32'd1; numberB = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    chk("intmin_ndone", ndone, 32'd1);
    chk("intmin_lat", dlat, 32'd33);
    chk("intmin_lo", r_lo, 32'h80000000);
    chk("intmin_hi", r_hi, 32'h0);
    chk("intmin_result", r_res, 32'h80000000);
    chk("intmin_dz", {31'b0, r_dz}, 32'h0);

    run(OP_SRA, 32'd4, 32'h80000000, lat, busy_ok);
    chk("sra_result", result, 32'hF8000000);
    run(OP_SLT, 32'hFFFFFFFF, 32'd1, lat, busy_ok);
    chk("slt_result", result, 32'd1);
    run(OP_SLTU, 32'hFFFFFFFF, 32'd1, lat, busy_ok);
    chk("sltu_result", result, 32'd0);
    run(OP_LUI, 32'd0, 32'h00001234, lat, busy_ok);
    chk("lui_result", result, 32'h12340000);
    run(OP_SUB, 32'd3, 32'd3, lat, busy_ok);
    chk("sub_result", result, 32'd0);
    chk("sub_zero", {31'b0, zero}, 32'h1);

    run(OP_MTHI, 32'hDEADBEEF, 32'd0, lat, busy_ok);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    run(OP_MFHI, 32'd0, 32'd0, lat, busy_ok);
    chk("b2b_lat", lat, 32'd1);
    chk("mfhi_result", result, 32'hDEADBEEF);
    chk("mfhi_lo", lo, 32'h80000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
